// File: rtl/vga_sync_scanner.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// vga_sync_scanner : VGA raster scan address generator with pixel-aligned
//                    registered sync and colour outputs.      Revision: 1.0
// ============================================================================
module vga_sync_scanner #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 42,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 31,
  parameter int COLOR_W   = 4
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Pixel,
  output logic [10:0]        Fila,
  output logic [10:0]        Columna,
  output logic               HSync,
  output logic               VSync,
  output logic [COLOR_W-1:0] Red,
  output logic [COLOR_W-1:0] Green,
  output logic [COLOR_W-1:0] Blue,
  output logic               Activo,
  output logic               FrameStart
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  logic [DIV_W-1:0]   div_q, div_d;
  logic [10:0]        col_q, col_d;
  logic [10:0]        row_q, row_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic [COLOR_W-1:0] rgb_q, rgb_d;
  logic               act_q, act_d;
  logic               fs_q, fs_d;

  logic pix_tick;
  logic line_end;
  logic frame_end;
  logic vis;

  always_comb begin
    pix_tick  = (div_q == DIV_W'(CLK_DIV - 1));
    line_end  = (col_q == 11'(H_TOTAL - 1));
    frame_end = line_end && (row_q == 11'(V_TOTAL - 1));
    vis       = (col_q < 11'(H_VISIBLE)) && (row_q < 11'(V_VISIBLE));

    div_d = pix_tick ? '0 : div_q + DIV_W'(1);
    col_d = col_q;
    row_d = row_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    rgb_d = rgb_q;
    act_d = act_q;
    fs_d  = 1'b0;

    // Output stage is computed from the address the VRAM reader has been
    // looking at for the whole pixel period, so colour and sync stay aligned.
    if (pix_tick) begin
      col_d = line_end ? '0 : col_q + 11'd1;
      if (line_end) begin
        row_d = frame_end ? '0 : row_q + 11'd1;
      end
      hs_d  = !((col_q >= 11'(HS_START)) && (col_q <= 11'(HS_END)));
      vs_d  = !((row_q >= 11'(VS_START)) && (row_q <= 11'(VS_END)));
      act_d = vis;
      rgb_d = (vis && Pixel) ? '1 : '0;
      fs_d  = frame_end;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      div_q <= '0;
      col_q <= '0;
      row_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      rgb_q <= '0;
      act_q <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      col_q <= col_d;
      row_q <= row_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
      act_q <= act_d;
      fs_q  <= fs_d;
    end
  end

  assign Fila       = row_q;
  assign Columna    = col_q;
  assign HSync      = hs_q;
  assign VSync      = vs_q;
  assign Red        = rgb_q;
  assign Green      = rgb_q;
  assign Blue       = rgb_q;
  assign Activo     = act_q;
  assign FrameStart = fs_q;

endmodule
`default_nettype wire
